// File: rtl/mantissa_normalizer_pipe.sv
// Two-stage mantissa shifter: right shift with sticky capture (mode 0) or
// left normalize with leading-zero count (mode 1), valid/ready on both sides.
module mantissa_normalizer_pipe #(
  parameter int WIDTH   = 11,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mant,
  input  logic [SHIFT_W-1:0] in_shamt,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_mant,
  output logic               out_sticky,
  output logic [SHIFT_W-1:0] out_lzc,
  output logic               out_zero
);

  logic               s1_valid, s2_valid;
  logic               s1_en, s2_en;
  logic [WIDTH-1:0]   s1_mant;
  logic [SHIFT_W-1:0] s1_shamt, s1_lzc;
  logic               s1_mode, s1_zero;

  logic [SHIFT_W-1:0] lzc_c;
  logic [WIDTH-1:0]   shift_mant_c, sticky_mask_c;
  logic               shift_sticky_c;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  // Scanning upward lets the highest set bit win; all-zero leaves WIDTH.
  always_comb begin
    lzc_c = SHIFT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_mant[i]) lzc_c = SHIFT_W'(WIDTH - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_shamt <= '0;
      s1_mode  <= 1'b0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant  <= in_mant;
        s1_shamt <= in_shamt;
        s1_mode  <= in_mode;
        s1_lzc   <= lzc_c;
        s1_zero  <= (in_mant == '0);
      end
    end
  end

  always_comb begin
    sticky_mask_c  = '0;
    shift_mant_c   = '0;
    shift_sticky_c = 1'b0;
    if (s1_mode) begin
      shift_mant_c = s1_mant << s1_lzc;
    end else if (s1_shamt >= SHIFT_W'(WIDTH)) begin
      shift_sticky_c = |s1_mant;
    end else begin
      sticky_mask_c  = (WIDTH'(1) << s1_shamt) - WIDTH'(1);
      shift_mant_c   = s1_mant >> s1_shamt;
      shift_sticky_c = |(s1_mant & sticky_mask_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_mant   <= '0;
      out_sticky <= 1'b0;
      out_lzc    <= '0;
      out_zero   <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant   <= shift_mant_c;
        out_sticky <= s1_mode ? 1'b0 : shift_sticky_c;
        out_lzc    <= s1_mode ? s1_lzc : '0;
        out_zero   <= s1_zero;
      end
    end
  end

endmodule
